// File: rtl/seg7_scan.sv
// Eight-digit multiplexed hex display driver: one digit is lit at a time and
// held for SCAN_DIV clocks. Anode and segment outputs are registered.
module seg7_scan #(
  parameter int SCAN_DIV = 50000
) (
  input  logic        clk_in,
  input  logic        rst_n,
  input  logic [31:0] data,
  input  logic        load,
  input  logic        en,
  input  logic        blank_lz,
  output logic [7:0]  an,
  output logic [6:0]  seg,
  output logic        dp,
  output logic        frame_done
);

  localparam int            PW        = $clog2(SCAN_DIV);
  localparam logic [PW-1:0] PRESC_MAX = PW'(SCAN_DIV - 1);

  logic [PW-1:0] presc;
  logic [2:0]    idx;
  logic [31:0]   shadow;
  logic          wrap;
  logic          blank;
  logic [3:0]    nib;
  logic [7:0]    an_nxt;
  logic [6:0]    seg_nxt;

  function automatic logic [6:0] hex_decode(input logic [3:0] v);
    logic [6:0] s;
    case (v)
      4'h0:    s = 7'h40;
      4'h1:    s = 7'h79;
      4'h2:    s = 7'h24;
      4'h3:    s = 7'h30;
      4'h4:    s = 7'h19;
      4'h5:    s = 7'h12;
      4'h6:    s = 7'h02;
      4'h7:    s = 7'h78;
      4'h8:    s = 7'h00;
      4'h9:    s = 7'h10;
      4'hA:    s = 7'h08;
      4'hB:    s = 7'h03;
      4'hC:    s = 7'h46;
      4'hD:    s = 7'h21;
      4'hE:    s = 7'h06;
      default: s = 7'h0E;
    endcase
    return s;
  endfunction

  assign wrap = (presc == PRESC_MAX);
  assign dp   = 1'b1;

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      presc      <= '0;
      idx        <= '0;
      shadow     <= '0;
      frame_done <= 1'b0;
      an         <= 8'hFF;
      seg        <= 7'h7F;
    end else begin
      presc      <= wrap ? '0 : presc + PW'(1);
      if (wrap) idx <= idx + 3'd1;
      if (load) shadow <= data;
      frame_done <= wrap && (idx == 3'd7);
      an         <= an_nxt;
      seg        <= seg_nxt;
    end
  end

  // A digit is blanked only if it and every digit to its left are zero.
  always_comb begin
    nib     = shadow[{idx, 2'b00} +: 4];
    blank   = blank_lz && (idx != 3'd0) && ((shadow >> {idx, 2'b00}) == 32'd0);
    an_nxt  = 8'hFF;
    seg_nxt = 7'h7F;
    if (en && !blank) begin
      an_nxt  = ~(8'h01 << idx);
      seg_nxt = hex_decode(nib);
    end
  end

endmodule

// File: doc/seg7_scan.md
SEG7_SCAN -- requirements
Module: seg7_scan

Interface
REQ-001 SHALL have parameter SCAN_DIV, default 50000, meaning the number of clk_in cycles each digit is held (legal range 2..2^20).
REQ-002 SHALL have port clk_in  input  1  system clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n  input  1  reset; one clock, reset is asynchronous and active-low.
REQ-004 SHALL have port data  input  32  display word; nibble i is shown on digit i, with digit 0 the rightmost.
REQ-005 SHALL have port load  input  1  data capture strobe.
REQ-006 SHALL have port en  input  1  display enable.
REQ-007 SHALL have port blank_lz  input  1  leading-zero blanking enable.
REQ-008 SHALL have port an  output  8  digit anodes, active-low, one-hot-low when a digit is lit.
REQ-009 SHALL have port seg  output  7  segments {g,f,e,d,c,b,a}, active-low.
REQ-010 SHALL have port dp  output  1  decimal point, active-low; held 1 (off).
REQ-011 SHALL have port frame_done  output  1  one-cycle pulse each time the digit index wraps from 7 to 0.

Function
REQ-012 SHALL hold a 32-bit shadow register; load=1 at a rising edge captures data, otherwise the shadow holds.
REQ-013 SHALL run a prescaler counting 0..SCAN_DIV-1 and wrapping to 0; it counts regardless of en.
REQ-014 SHALL hold a 3-bit digit index that advances by 1 in the cycle where the prescaler equals SCAN_DIV-1; it wraps 7->0.
REQ-015 SHALL assert frame_done for exactly the one cycle after the index transitions 7->0, and be 0 at all other times.
REQ-016 SHALL register an, seg and dp from the current index and shadow: outputs reflect the index/shadow state of the previous cycle (1-cycle latency).
REQ-017 With en=1 and the digit not blanked, an SHALL equal ~(8'b1 << idx) and seg SHALL equal the hex decode of shadow[4*idx+3 : 4*idx].
REQ-018 The hex decode SHALL be: 0=40 1=79 2=24 3=30 4=19 5=12 6=02 7=78 8=00 9=10 A=08 b=03 C=46 d=21 E=06 F=0E (hex, 7-bit).
REQ-019 A digit idx>0 SHALL be blanked when blank_lz=1 and shadow nibbles idx..7 are all zero; digit 0 is never blanked.
REQ-020 A blanked digit SHALL drive an=8'hFF and seg=7'h7F.
REQ-021 With en=0, an SHALL be 8'hFF and seg SHALL be 7'h7F; the index keeps advancing.
REQ-022 When load and a prescaler wrap occur in the same cycle, both SHALL take effect, and the next digit shows the new shadow value.
REQ-023 A change of blank_lz or en SHALL take effect on the outputs one cycle later, with no frame restart.

Reset
REQ-024 While rst_n=0: prescaler=0, index=0, shadow=0, an=8'hFF, seg=7'h7F, dp=1, frame_done=0, applied immediately without a clock.
REQ-025 Deassertion of rst_n mid-scan SHALL restart at digit 0 with a full SCAN_DIV hold period; the first active output appears 1 cycle after release.

Verification (bench uses SCAN_DIV=4)
REQ-026 Reset: rst_n=0 asynchronously mid-scan -> an=FF, seg=7F, frame_done=0 within the same time step, before any clock edge.
REQ-027 Scan: load data=32'h76543210, en=1, blank_lz=0 -> an steps FE,FD,FB,...,7F every 4 cycles, seg sequence 40,79,24,30,19,12,02,78.
REQ-028 Wrap: continuing REQ-027 -> frame_done pulses once per 32 cycles, exactly 1 cycle wide, aligned to the 7->0 index transition.
REQ-029 Blanking: data=32'h000000A5, blank_lz=1 -> digits 0 and 1 show 12 and 08; digits 2..7 show an=FF, seg=7F. Repeat with data=0 -> only digit 0 is lit, showing 40.
REQ-030 Simultaneous: load 32'hFFFFFFFF on the cycle the prescaler wraps from digit 2 to digit 3 -> digit 3 shows seg=0E, an=F7.
REQ-031 Enable: en=0 during a scan -> an=FF one cycle later; on en=1 the scan resumes at the current index, with no reset of the index or prescaler.
